cipher_group_formatter: RTL and testbench
=========================================

CIPHER_GROUP_FORMATTER -- requirements
Module: cipher_group_formatter

Interface
REQ-001 SHALL provide parameter GROUP_LEN, default 5, letters per output group.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, input buffer entries (power of two).
REQ-003 SHALL provide parameter PAD_CHAR, default 8'h58 ("X"), filler that completes a partial group on flush.
REQ-004 SHALL provide parameter SEP_CHAR, default 8'h20 (space), group separator.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports: clock  in  1  rising-edge clock.
REQ-007 reset  in  1  async active-high reset.
REQ-008 inChar  in  8  ASCII cipher character from the upstream cipher stage.
REQ-009 inValid  in  1  inChar is valid.
REQ-010 inReady  out  1  block accepts inChar this cycle.
REQ-011 flush  in  1  one-cycle request that pads and closes the current message.
REQ-012 outChar  out  8  formatted ASCII stream.
REQ-013 outValid  out  1  outChar is valid.
REQ-014 outReady  in  1  downstream accepts outChar.
REQ-015 badChar  out  1  one-cycle pulse when an accepted inChar is outside "A".."Z".
REQ-016 flushDone  out  1  one-cycle pulse when the flush completes.
REQ-017 groupCount  out  16  number of completed groups emitted since reset; wraps 65535->0.

Function
REQ-018 The input handshake SHALL complete on a rising edge where inValid && inReady.
REQ-019 inReady SHALL equal (fifo count < FIFO_DEPTH) && !flushPending and SHALL be decoded from registers only.
REQ-020 An accepted character outside 8'h41..8'h5A SHALL be discarded (not written) and badChar SHALL pulse on the next cycle.
REQ-021 The output handshake SHALL complete on a rising edge where outValid && outReady; outChar/outValid SHALL be registered and held stable while outValid && !outReady.
REQ-022 A letter written into an empty FIFO at edge N with outReady=1 SHALL appear on outChar/outValid after edge N+1.
REQ-023 The FSM SHALL have states EMIT, SEP, PAD; reset state EMIT, position counter pos=0.
REQ-024 EMIT: when the FIFO is non-empty and pos<GROUP_LEN, pop one letter, present it, and pos++.
REQ-025 EMIT, pos==GROUP_LEN, FIFO non-empty -> SEP: present SEP_CHAR, then pos=0 and return to EMIT.
REQ-026 The separator SHALL be emitted lazily, so no trailing separator ever appears.
REQ-027 groupCount SHALL increment when the GROUP_LEN-th character of a group, letter or pad, completes its handshake.
REQ-028 flush SHALL set flushPending; a flush that arrives while flushPending is set SHALL be ignored.
REQ-029 flushPending, FIFO empty, 0<pos<GROUP_LEN -> PAD: present PAD_CHAR until pos==GROUP_LEN.
REQ-030 On flush completion (FIFO empty and pos==0 or pos==GROUP_LEN), the block SHALL pulse flushDone, clear flushPending, set pos=0, and enter EMIT; the next message SHALL start without a separator.
REQ-031 A flush with FIFO empty and pos==0 SHALL pulse flushDone on the next cycle and emit nothing.
REQ-032 Simultaneous push and pop SHALL both occur, with the count unchanged.
REQ-033 Simultaneous flush and accepted inChar: the inChar SHALL be included before padding.

Reset
REQ-034 Reset SHALL clear the FIFO pointers and count, pos, flushPending, and groupCount, and set the state to EMIT.
REQ-035 Reset values: outChar=8'h00, outValid=0, badChar=0, flushDone=0, inReady=1 after release.
REQ-036 Reset mid-group or mid-flush SHALL abandon all buffered and partial output with no pad emitted.

Structure
REQ-037 The shared package SHALL hold the state enumeration, ASCII constants ("A", "Z", space, "X"), and the GROUP_LEN/FIFO_DEPTH defaults.
REQ-038 The FIFO SHALL be one sub-module, char_fifo (8-bit, parameter depth, count output); the FSM SHALL live in the top level.

Verification
REQ-039 Feed "HELLOWORLD" with outReady=1 -> "HELLO WORLD"; groupCount=2; no trailing space.
REQ-040 Feed "ABCDEFG", then flush -> "ABCDE FGXXX"; one flushDone pulse; groupCount=2; then "QR"+flush -> "QRXXX" with no leading space.
REQ-041 Hold outReady=0 and push 8 letters -> inReady=0 after the 8th; the 9th is not accepted; outChar="A" stays stable; release -> the 8 letters drain in order.
REQ-042 Feed "A","1","B" -> output "AB"; badChar pulses exactly once.
REQ-043 Push "ABC", assert reset while "B" is presented -> all outputs are at reset values; a following "Z"+flush -> "ZXXXX".
REQ-044 flush with nothing buffered -> flushDone after 1 cycle; outValid never asserted.

Source files
------------

// File: rtl/cipher_group_formatter_pkg.sv
// cipher_group_formatter_pkg: shared states, ASCII constants and defaults for the group formatter
package cipher_group_formatter_pkg;
   typedef enum logic [1:0] {EMIT, SEP, PAD} fmtState;
   localparam logic [7:0] CHAR_A = 8'h41;
   localparam logic [7:0] CHAR_Z = 8'h5A;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_X = 8'h58;
   localparam int DEFAULT_GROUP_LEN = 5;
   localparam int DEFAULT_FIFO_DEPTH = 8;
   function automatic logic isLetter(input logic [7:0] c);
      return (c >= CHAR_A) && (c <= CHAR_Z);
   endfunction
endpackage

// File: rtl/cipher_group_formatter_char_fifo.sv
// char_fifo: 8-bit input buffer exposing the head and the entry behind it plus an occupancy count
module char_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wrEn,
   input  logic [7:0]               wrData,
   input  logic                     rdEn,
   output logic [7:0]               rdData,
   output logic [7:0]               rdNext,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   assign rdData = mem[rdPtr];
   assign rdNext = mem[rdPtr + AW'(1)];
   // storage carries no reset; only the pointers define what is valid
   always_ff @(posedge clock) begin
      if (wrEn) mem[wrPtr] <= wrData;
   end
   // pointer and occupancy bookkeeping, push and pop may coincide
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         wrPtr <= wrEn ? wrPtr + AW'(1) : wrPtr;
         rdPtr <= rdEn ? rdPtr + AW'(1) : rdPtr;
         count <= count + CW'(wrEn) - CW'(rdEn);
      end
   end
endmodule

// File: rtl/cipher_group_formatter.sv
// cipher_group_formatter: buffers cipher letters and emits them in fixed-size groups with separators and flush padding
module cipher_group_formatter
   import cipher_group_formatter_pkg::*;
#(
   parameter int          GROUP_LEN  = DEFAULT_GROUP_LEN,
   parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter logic [7:0]  PAD_CHAR   = CHAR_X,
   parameter logic [7:0]  SEP_CHAR   = CHAR_SPACE
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   inChar,
   input  logic         inValid,
   output logic         inReady,
   input  logic         flush,
   output logic [7:0]   outChar,
   output logic         outValid,
   input  logic         outReady,
   output logic         badChar,
   output logic         flushDone,
   output logic [15:0]  groupCount
);
   localparam int PW = $clog2(GROUP_LEN + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PW-1:0] LAST = PW'(GROUP_LEN);
   localparam logic [PW-1:0] PRE_LAST = PW'(GROUP_LEN - 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   fmtState state;
   logic [PW-1:0] pos;
   logic flushPending, outIsLetter, outLast;
   logic [CW-1:0] fifoCount, avail;
   logic [7:0] headChar, nextChar;
   logic accept, wrEn, rdEn, canLoad, holdLetter, loadLetter, fifoEmpty;
   assign inReady = (fifoCount < FULL) && !flushPending;
   // a presented letter stays in the FIFO until its handshake, so the buffer limit covers it too
   always_comb begin
      accept = inValid && inReady;
      wrEn = accept && isLetter(inChar);
      holdLetter = outValid && outIsLetter;
      rdEn = holdLetter && outReady;
      canLoad = !outValid || outReady;
      avail = fifoCount - CW'(holdLetter);
      fifoEmpty = fifoCount == '0;
      loadLetter = (state == EMIT) && canLoad && (avail != '0) && (pos < LAST);
   end
   char_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
      .clock  (clock),
      .reset  (reset),
      .wrEn   (wrEn),
      .wrData (inChar),
      .rdEn   (rdEn),
      .rdData (headChar),
      .rdNext (nextChar),
      .count  (fifoCount)
   );
   // grouping FSM with registered output stage; separators only appear once the next letter exists
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= EMIT;
         pos <= '0;
         flushPending <= 1'b0;
         outChar <= 8'h00;
         outValid <= 1'b0;
         outIsLetter <= 1'b0;
         outLast <= 1'b0;
         badChar <= 1'b0;
         flushDone <= 1'b0;
         groupCount <= '0;
      end else begin
         badChar <= accept && !isLetter(inChar);
         flushDone <= 1'b0;
         if (flush) flushPending <= 1'b1;
         if (outValid && outReady) begin
            outValid <= 1'b0;
            if (outLast) groupCount <= groupCount + 16'd1;
         end
         case (state)
            EMIT: begin
               if (loadLetter) begin
                  outChar <= holdLetter ? nextChar : headChar;
                  outValid <= 1'b1;
                  outIsLetter <= 1'b1;
                  outLast <= pos == PRE_LAST;
                  pos <= pos + PW'(1);
               end else if (canLoad && avail != '0) begin
                  outChar <= SEP_CHAR;
                  outValid <= 1'b1;
                  outIsLetter <= 1'b0;
                  outLast <= 1'b0;
                  state <= SEP;
               end else if (flushPending && fifoEmpty && pos != '0 && pos != LAST) begin
                  state <= PAD;
               end else if (flushPending && fifoEmpty) begin
                  flushDone <= 1'b1;
                  flushPending <= 1'b0;
                  pos <= '0;
               end
            end
            SEP: begin
               if (canLoad) begin
                  pos <= '0;
                  state <= EMIT;
               end
            end
            PAD: begin
               if (pos != LAST) begin
                  if (canLoad) begin
                     outChar <= PAD_CHAR;
                     outValid <= 1'b1;
                     outIsLetter <= 1'b0;
                     outLast <= pos == PRE_LAST;
                     pos <= pos + PW'(1);
                  end
               end else begin
                  flushDone <= 1'b1;
                  flushPending <= 1'b0;
                  pos <= '0;
                  state <= EMIT;
               end
            end
            default: state <= EMIT;
         endcase
      end
   end
endmodule

// File: tb/tb_cipher_group_formatter.sv
// tb_cipher_group_formatter: directed checks of grouping, padding, backpressure, bad input and reset
module tb_cipher_group_formatter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [7:0] inChar = 8'h00;
   logic inValid = 1'b0;
   logic inReady;
   logic flush = 1'b0;
   logic [7:0] outChar;
   logic outValid;
   logic outReady = 1'b1;
   logic badChar;
   logic flushDone;
   logic [15:0] groupCount;
   int compared = 0;
   int mismatched = 0;
   logic [7:0] q[$];
   int badCnt = 0;
   int fdCnt = 0;
   int validCnt = 0;

   cipher_group_formatter dut (
      .clock      (clock),
      .reset      (reset),
      .inChar     (inChar),
      .inValid    (inValid),
      .inReady    (inReady),
      .flush      (flush),
      .outChar    (outChar),
      .outValid   (outValid),
      .outReady   (outReady),
      .badChar    (badChar),
      .flushDone  (flushDone),
      .groupCount (groupCount)
   );

   always #5 clock = ~clock;

   // capture the stream and pulse counts on the falling edge, away from the active edge
   always @(negedge clock) begin
      if (!reset) begin
         if (outValid && outReady) q.push_back(outChar);
         if (badChar) badCnt++;
         if (flushDone) fdCnt++;
         if (outValid) validCnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkStream(input string tag, input int start, input string exp);
      string obs = "";
      for (int i = start; i < q.size(); i++) obs = $sformatf("%s%c", obs, q[i]);
      compared++;
      assert (obs == exp) else begin
         mismatched++;
         $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] c);
      int n = 0;
      inChar = c;
      inValid = 1'b1;
      while (!inReady && n < 200) begin
         tick();
         n++;
      end
      tick();
      inValid = 1'b0;
   endtask

   task automatic pushStr(input string s);
      for (int i = 0; i < s.len(); i++) push(s[i]);
   endtask

   task automatic doFlush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic waitOut(input int target);
      int n = 0;
      while (q.size() < target && n < 300) begin
         tick();
         n++;
      end
      repeat (12) tick();
   endtask

   initial begin
      int n0, n1, fd0, b0, v0, n;
      repeat (2) tick();
      chk("rst_outChar", outChar, 8'h00);
      chk("rst_outValid", outValid, 0);
      chk("rst_badChar", badChar, 0);
      chk("rst_flushDone", flushDone, 0);
      chk("rst_groupCount", groupCount, 0);
      reset = 1'b0;
      tick();
      chk("rst_inReady", inReady, 1);

      n0 = q.size();
      inChar = "H";
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      chk("lat_notyet", outValid, 0);
      tick();
      chk("lat_valid", outValid, 1);
      chk("lat_char", outChar, "H");
      pushStr("ELLOWORLD");
      waitOut(n0 + 11);
      checkStream("hello_stream", n0, "HELLO WORLD");
      chk("hello_groups", groupCount, 2);
      chk("hello_idle", outValid, 0);
      fd0 = fdCnt;
      doFlush();
      repeat (6) tick();
      chk("hello_flushDone", fdCnt - fd0, 1);
      checkStream("hello_noextra", n0, "HELLO WORLD");

      n0 = q.size();
      fd0 = fdCnt;
      pushStr("ABCDEFG");
      doFlush();
      waitOut(n0 + 11);
      checkStream("pad_stream", n0, "ABCDE FGXXX");
      chk("pad_flushDone", fdCnt - fd0, 1);
      chk("pad_groups", groupCount, 4);
      n1 = q.size();
      pushStr("QR");
      doFlush();
      waitOut(n1 + 5);
      checkStream("qr_stream", n1, "QRXXX");
      chk("qr_groups", groupCount, 5);

      outReady = 1'b0;
      n0 = q.size();
      pushStr("ABCDEFGH");
      chk("bp_full", inReady, 0);
      inChar = "I";
      inValid = 1'b1;
      repeat (3) tick();
      chk("bp_still_full", inReady, 0);
      chk("bp_valid", outValid, 1);
      chk("bp_hold_char", outChar, "A");
      inValid = 1'b0;
      outReady = 1'b1;
      doFlush();
      waitOut(n0 + 11);
      checkStream("bp_stream", n0, "ABCDE FGHXX");
      chk("bp_groups", groupCount, 7);

      n0 = q.size();
      b0 = badCnt;
      pushStr("A1B");
      doFlush();
      waitOut(n0 + 5);
      checkStream("bad_stream", n0, "ABXXX");
      chk("bad_pulses", badCnt - b0, 1);
      chk("bad_groups", groupCount, 8);

      v0 = validCnt;
      fd0 = fdCnt;
      doFlush();
      chk("empty_fd_early", flushDone, 0);
      tick();
      chk("empty_fd_pulse", flushDone, 1);
      tick();
      chk("empty_fd_clear", flushDone, 0);
      repeat (5) tick();
      chk("empty_no_valid", validCnt - v0, 0);
      chk("empty_fd_count", fdCnt - fd0, 1);
      chk("empty_groups", groupCount, 8);

      pushStr("ABC");
      n = 0;
      while (!(outValid && outChar == "B") && n < 50) begin
         tick();
         n++;
      end
      chk("mid_seen_B", outChar, "B");
      reset = 1'b1;
      #1;
      chk("mid_rst_outChar", outChar, 8'h00);
      chk("mid_rst_outValid", outValid, 0);
      chk("mid_rst_badChar", badChar, 0);
      chk("mid_rst_flushDone", flushDone, 0);
      chk("mid_rst_groups", groupCount, 0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("mid_rst_inReady", inReady, 1);
      chk("mid_rst_idle", outValid, 0);
      n0 = q.size();
      push("Z");
      doFlush();
      waitOut(n0 + 5);
      checkStream("mid_rst_stream", n0, "ZXXXX");
      chk("mid_rst_groups_after", groupCount, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
